// File: rtl/riscv_cpu_top.sv
// riscv_cpu_top: single-cycle RV32I core with separate instruction/data buses.
// Any illegal instruction or misaligned access latches a sticky error and halts the core.
module riscv_cpu_top (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic [31:0] s_boot_add_i,
    output logic        s_error_o,
    input  logic [31:0] s_ibus_val_i,
    output logic        s_ibus_write_o,
    output logic [31:0] s_ibus_add_o,
    output logic [31:0] s_ibus_val_o,
    input  logic [31:0] s_dbus_val_i,
    output logic        s_dbus_write_o,
    output logic [31:0] s_dbus_add_o,
    output logic [31:0] s_dbus_val_o
);
    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_FENCE  = 7'b0001111
    } opcode_e;

    logic [31:0] pc_q;
    logic        error_q;
    logic [31:0] regs_q [32];

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, pc_plus4;

    assign instr  = s_ibus_val_i;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
    assign pc_plus4 = pc_q + 32'd4;

    logic [31:0] alu_b, alu_res, sra_res;

    assign alu_b   = (opcode == OP_REG) ? rs2_val : imm_i;
    assign sra_res = $signed(rs1_val) >>> alu_b[4:0];

    always_comb begin
        case (funct3)
            3'b000:  alu_res = (opcode == OP_REG && funct7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001:  alu_res = rs1_val << alu_b[4:0];
            3'b010:  alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_res = {31'd0, rs1_val < alu_b};
            3'b100:  alu_res = rs1_val ^ alu_b;
            3'b101:  alu_res = funct7[5] ? sra_res : rs1_val >> alu_b[4:0];
            3'b110:  alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    logic branch_cond;

    always_comb begin
        case (funct3)
            3'b000:  branch_cond = (rs1_val == rs2_val);
            3'b001:  branch_cond = (rs1_val != rs2_val);
            3'b100:  branch_cond = ($signed(rs1_val) < $signed(rs2_val));
            3'b101:  branch_cond = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  branch_cond = (rs1_val < rs2_val);
            3'b111:  branch_cond = (rs1_val >= rs2_val);
            default: branch_cond = 1'b0;
        endcase
    end

    logic        illegal, rd_we, redirect, is_load, is_store, fault;
    logic [31:0] rd_data, target, mem_addr, next_pc;

    assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);

    always_comb begin
        illegal  = 1'b0;
        rd_we    = 1'b0;
        rd_data  = alu_res;
        redirect = 1'b0;
        target   = pc_q + imm_b;
        is_load  = 1'b0;
        is_store = 1'b0;
        case (opcode)
            OP_LUI: begin
                rd_we   = 1'b1;
                rd_data = imm_u;
            end
            OP_AUIPC: begin
                rd_we   = 1'b1;
                rd_data = pc_q + imm_u;
            end
            OP_JAL: begin
                rd_we    = 1'b1;
                rd_data  = pc_plus4;
                redirect = 1'b1;
                target   = pc_q + imm_j;
            end
            OP_JALR: begin
                if (funct3 != 3'b000) begin
                    illegal = 1'b1;
                end else begin
                    rd_we    = 1'b1;
                    rd_data  = pc_plus4;
                    redirect = 1'b1;
                    target   = (rs1_val + imm_i) & ~32'd1;
                end
            end
            OP_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) illegal = 1'b1;
                else redirect = branch_cond;
            end
            OP_LOAD: begin
                if (funct3 != 3'b010) begin
                    illegal = 1'b1;
                end else begin
                    is_load = 1'b1;
                    rd_we   = 1'b1;
                    rd_data = s_dbus_val_i;
                end
            end
            OP_STORE: begin
                if (funct3 != 3'b010) illegal = 1'b1;
                else is_store = 1'b1;
            end
            OP_IMM: begin
                // funct7 only qualifies the shift forms; elsewhere it is immediate bits
                if ((funct3 == 3'b001 && funct7 != 7'd0) ||
                    (funct3 == 3'b101 && funct7 != 7'd0 && funct7 != 7'b0100000))
                    illegal = 1'b1;
                else
                    rd_we = 1'b1;
            end
            OP_REG: begin
                if (funct7 == 7'd0 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
                    rd_we = 1'b1;
                else
                    illegal = 1'b1;
            end
            OP_FENCE: begin
                if (funct3 != 3'b000) illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign fault = illegal ||
                   ((is_load || is_store) && mem_addr[1:0] != 2'b00) ||
                   (redirect && target[1:0] != 2'b00);
    assign next_pc = redirect ? target : pc_plus4;

    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i) begin
            pc_q    <= s_boot_add_i;
            error_q <= 1'b0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (!error_q) begin
            if (fault) begin
                error_q <= 1'b1;
            end else begin
                pc_q <= next_pc;
                if (rd_we && rd != 5'd0) regs_q[rd] <= rd_data;
            end
        end
    end

    assign s_ibus_write_o = 1'b0;
    assign s_ibus_val_o   = 32'd0;
    assign s_ibus_add_o   = pc_q;
    assign s_dbus_add_o   = (is_load || is_store) ? mem_addr : alu_res;
    assign s_dbus_val_o   = rs2_val;
    assign s_dbus_write_o = is_store && !fault && !error_q && s_resetn_i;
    assign s_error_o      = error_q && s_resetn_i;
endmodule

// File: tb/tb_riscv_cpu_top.sv
// tb_riscv_cpu_top: directed and randomized programs for the RV32I core,
// checked against an instruction-level reference model and known results.
module tb_riscv_cpu_top;
    localparam logic [31:0] FILL = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] boot = 32'd0;
    logic        error, ibus_write, dbus_write;
    logic [31:0] ibus_val, ibus_add, ibus_val_o, dbus_val, dbus_add, dbus_val_o;
    logic [31:0] imem [1024];
    logic [31:0] dmem [1024];
    logic        dmem_clear = 1'b0;
    logic [31:0] mreg [32];
    int          gen_pc;
    int          n_pass = 0;
    int          n_total = 0;
    int          r_f3 [10] = '{0, 0, 1, 2, 3, 4, 6, 7, 5, 5};
    int          r_f7 [10] = '{0, 32, 0, 0, 0, 0, 0, 0, 0, 32};
    int          b_f3 [6]  = '{0, 1, 4, 5, 6, 7};

    always #5 clk = ~clk;

    riscv_cpu_top dut (
        .s_clk_i        (clk),
        .s_resetn_i     (resetn),
        .s_boot_add_i   (boot),
        .s_error_o      (error),
        .s_ibus_val_i   (ibus_val),
        .s_ibus_write_o (ibus_write),
        .s_ibus_add_o   (ibus_add),
        .s_ibus_val_o   (ibus_val_o),
        .s_dbus_val_i   (dbus_val),
        .s_dbus_write_o (dbus_write),
        .s_dbus_add_o   (dbus_add),
        .s_dbus_val_o   (dbus_val_o)
    );

    assign ibus_val = imem[ibus_add[11:2]];
    assign dbus_val = dmem[dbus_add[11:2]];

    // Data memory: refilled with a sentinel on request, otherwise written by the core
    always @(posedge clk) begin
        if (dmem_clear) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= FILL;
        end else if (dbus_write === 1'b1) begin
            dmem[dbus_add[11:2]] <= dbus_val_o;
        end
    end

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2, input int off);
        return {off[12], off[10:5], rs2[4:0], rs1[4:0], f3[2:0], off[4:1], off[11], 7'h63};
    endfunction
    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 0, rd, 'h13);
    endfunction
    function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 2, rd, 'h03);
    endfunction
    function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] lui(input int rd, input int imm20);
        return {imm20[19:0], rd[4:0], 7'h37};
    endfunction
    function automatic logic [31:0] jal(input int rd, input int off);
        return {off[20], off[10:1], off[11], off[19:12], rd[4:0], 7'h6f};
    endfunction
    function automatic logic [31:0] jalr(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 0, rd, 'h67);
    endfunction

    // ISA-level semantics: 0 add 1 sub 2 sll 3 slt 4 sltu 5 xor 6 or 7 and 8 srl 9 sra
    function automatic logic [31:0] model_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a << b[4:0];
            3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4: return (a < b) ? 32'd1 : 32'd0;
            5: return a ^ b;
            6: return a | b;
            7: return a & b;
            8: return a >> b[4:0];
            default: return $signed(a) >>> b[4:0];
        endcase
    endfunction

    function automatic bit model_branch(input int f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            0: return a == b;
            1: return a != b;
            4: return $signed(a) < $signed(b);
            5: return $signed(a) >= $signed(b);
            6: return a < b;
            default: return a >= b;
        endcase
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 1024; i++) imem[i] = 32'd0;
        gen_pc = 0;
    endtask

    task automatic emit(input logic [31:0] w);
        imem[gen_pc / 4] = w;
        gen_pc += 4;
    endtask

    task automatic do_reset(input logic [31:0] b);
        @(negedge clk);
        boot       = b;
        resetn     = 1'b0;
        dmem_clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dmem_clear = 1'b0;
        resetn     = 1'b1;
    endtask

    // Returns the number of edges after reset release until the error flag is seen, or -1
    task automatic wait_error(output int cycles);
        cycles = -1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (error === 1'b1) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int c;
        clear_imem();
        boot = 32'h200;
        resetn = 1'b0;
        dmem_clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dmem_clear = 1'b0;
        n_total++;
        if (ibus_add !== 32'h200) $display("[TB] FAIL reset_pc: got %h expected %h", ibus_add, 32'h200);
        else n_pass++;
        n_total++;
        if (error !== 1'b0) $display("[TB] FAIL reset_error: got %b expected 0", error);
        else n_pass++;
        n_total++;
        if (dbus_write !== 1'b0) $display("[TB] FAIL reset_dwrite: got %b expected 0", dbus_write);
        else n_pass++;
        n_total++;
        if (ibus_write !== 1'b0 || ibus_val_o !== 32'd0)
            $display("[TB] FAIL ibus_tied: got %b/%h expected 0/0", ibus_write, ibus_val_o);
        else n_pass++;
        resetn = 1'b1;
        wait_error(c);
        n_total++;
        if (c !== 1) $display("[TB] FAIL zero_word_error: got cycle %0d expected 1", c);
        else n_pass++;
        n_total++;
        if (ibus_add !== 32'h200) $display("[TB] FAIL zero_word_pc: got %h expected %h", ibus_add, 32'h200);
        else n_pass++;
    endtask

    task automatic test_basic_alu();
        int c;
        clear_imem();
        emit(addi(1, 0, 5));
        emit(addi(2, 0, -3));
        emit(enc_r(0, 2, 1, 0, 3));
        emit(sw(3, 0, 0));
        emit(32'd0);
        do_reset(32'd0);
        wait_error(c);
        n_total++;
        if (c !== 5) $display("[TB] FAIL basic_cycles: got %0d expected 5", c);
        else n_pass++;
        n_total++;
        if (dmem[0] !== 32'd2) $display("[TB] FAIL basic_sum: got %h expected %h", dmem[0], 32'd2);
        else n_pass++;
    endtask

    task automatic test_load_store();
        int c;
        clear_imem();
        emit(lui(1, 'h12345));
        emit(addi(1, 1, 'h678));
        emit(sw(1, 0, 4));
        emit(lw(2, 0, 4));
        emit(sw(2, 0, 8));
        emit(32'd0);
        do_reset(32'd0);
        wait_error(c);
        n_total++;
        if (c !== 6) $display("[TB] FAIL ls_cycles: got %0d expected 6", c);
        else n_pass++;
        for (int i = 1; i <= 2; i++) begin
            n_total++;
            if (dmem[i] !== 32'h12345678) $display("[TB] FAIL ls_dmem%0d: got %h expected 12345678", i, dmem[i]);
            else n_pass++;
        end
    endtask

    task automatic test_branches();
        int c;
        clear_imem();
        emit(addi(1, 0, -1));
        emit(addi(2, 0, 1));
        emit(addi(3, 0, 1));
        emit(enc_b(4, 1, 2, 8));
        emit(addi(3, 0, 0));
        emit(sw(3, 0, 0));
        emit(addi(4, 0, 1));
        emit(enc_b(6, 1, 2, 8));
        emit(addi(4, 0, 0));
        emit(sw(4, 0, 4));
        emit(32'd0);
        do_reset(32'd0);
        wait_error(c);
        n_total++;
        if (c !== 10) $display("[TB] FAIL br_cycles: got %0d expected 10", c);
        else n_pass++;
        n_total++;
        if (dmem[0] !== 32'd1) $display("[TB] FAIL blt_signed: got %h expected 1", dmem[0]);
        else n_pass++;
        n_total++;
        if (dmem[1] !== 32'd0) $display("[TB] FAIL bltu_unsigned: got %h expected 0", dmem[1]);
        else n_pass++;
    endtask

    task automatic test_jumps();
        int c;
        clear_imem();
        imem['h10 / 4] = jal(1, 8);
        imem['h14 / 4] = jal(0, 'h10);
        imem['h18 / 4] = sw(1, 0, 0);
        imem['h1C / 4] = jalr(0, 1, 1);
        imem['h24 / 4] = addi(0, 0, 5);
        imem['h28 / 4] = sw(0, 0, 4);
        imem['h2C / 4] = addi(2, 0, 'h55);
        imem['h30 / 4] = sw(2, 0, 8);
        imem['h34 / 4] = sw(1, 0, 12);
        do_reset(32'h10);
        wait_error(c);
        n_total++;
        if (c !== 10) $display("[TB] FAIL jmp_cycles: got %0d expected 10", c);
        else n_pass++;
        n_total++;
        if (dmem[0] !== 32'h14) $display("[TB] FAIL jal_link: got %h expected 14", dmem[0]);
        else n_pass++;
        n_total++;
        if (dmem[1] !== 32'd0) $display("[TB] FAIL x0_write: got %h expected 0", dmem[1]);
        else n_pass++;
        n_total++;
        if (dmem[2] !== 32'h55) $display("[TB] FAIL jalr_return: got %h expected 55", dmem[2]);
        else n_pass++;
        n_total++;
        if (dmem[3] !== 32'h14) $display("[TB] FAIL jalr_x0_link: got %h expected 14", dmem[3]);
        else n_pass++;
        n_total++;
        if (ibus_add !== 32'h38) $display("[TB] FAIL jmp_final_pc: got %h expected 38", ibus_add);
        else n_pass++;
    endtask

    task automatic test_shifts();
        int c;
        clear_imem();
        emit(lui(1, 'h80000));
        emit(enc_i('h404, 1, 5, 2, 'h13));
        emit(enc_i(4, 1, 5, 3, 'h13));
        emit(enc_i(1, 0, 3, 4, 'h13));
        emit(sw(2, 0, 0));
        emit(sw(3, 0, 4));
        emit(sw(4, 0, 8));
        emit(32'd0);
        do_reset(32'd0);
        wait_error(c);
        n_total++;
        if (c !== 8) $display("[TB] FAIL sh_cycles: got %0d expected 8", c);
        else n_pass++;
        n_total++;
        if (dmem[0] !== 32'hF8000000) $display("[TB] FAIL srai: got %h expected F8000000", dmem[0]);
        else n_pass++;
        n_total++;
        if (dmem[1] !== 32'h08000000) $display("[TB] FAIL srli: got %h expected 08000000", dmem[1]);
        else n_pass++;
        n_total++;
        if (dmem[2] !== 32'd1) $display("[TB] FAIL sltiu: got %h expected 1", dmem[2]);
        else n_pass++;
    endtask

    task automatic test_error();
        int c;
        clear_imem();
        emit(addi(1, 0, 7));
        emit(sw(1, 0, 1));
        do_reset(32'd0);
        wait_error(c);
        n_total++;
        if (c !== 2) $display("[TB] FAIL sw_misalign_cycle: got %0d expected 2", c);
        else n_pass++;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            n_total++;
            if (dbus_write !== 1'b0) $display("[TB] FAIL halt_dwrite: got %b expected 0", dbus_write);
            else n_pass++;
        end
        n_total++;
        if (dmem[0] !== FILL) $display("[TB] FAIL sw_misalign_nowrite: got %h expected %h", dmem[0], FILL);
        else n_pass++;
        n_total++;
        if (ibus_add !== 32'd4 || error !== 1'b1)
            $display("[TB] FAIL halt_pc: got %h/%b expected 00000004/1", ibus_add, error);
        else n_pass++;

        clear_imem();
        emit(enc_b(1, 0, 0, 6));
        emit(enc_b(0, 0, 0, 6));
        do_reset(32'd0);
        wait_error(c);
        n_total++;
        if (c !== 2 || ibus_add !== 32'd4)
            $display("[TB] FAIL br_misalign: got cycle %0d pc %h expected 2/00000004", c, ibus_add);
        else n_pass++;

        clear_imem();
        emit(lw(1, 0, 2));
        imem['h100 / 4] = addi(2, 0, 9);
        imem['h104 / 4] = sw(2, 0, 12);
        do_reset(32'd0);
        wait_error(c);
        n_total++;
        if (c !== 1 || ibus_add !== 32'd0 || dbus_write !== 1'b0)
            $display("[TB] FAIL lw_misalign: got cycle %0d pc %h wr %b expected 1/0/0", c, ibus_add, dbus_write);
        else n_pass++;
        @(negedge clk);
        resetn = 1'b0;
        boot   = 32'h100;
        #1;
        n_total++;
        if (error !== 1'b0) $display("[TB] FAIL error_in_reset: got %b expected 0", error);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if (ibus_add !== 32'h100) $display("[TB] FAIL restart_pc: got %h expected 00000100", ibus_add);
        else n_pass++;
        resetn = 1'b1;
        wait_error(c);
        n_total++;
        if (c !== 3 || dmem[3] !== 32'd9)
            $display("[TB] FAIL restart_run: got cycle %0d dmem %h expected 3/00000009", c, dmem[3]);
        else n_pass++;
    endtask

    task automatic test_illegal();
        int c;
        logic [31:0] bad [6];
        bad[0] = 32'h00000073;
        bad[1] = 32'h00100073;
        bad[2] = 32'h34011073;
        bad[3] = 32'h00004083;
        bad[4] = 32'h00100023;
        bad[5] = enc_r(1, 2, 1, 0, 3);
        for (int i = 0; i < 6; i++) begin
            clear_imem();
            emit(bad[i]);
            do_reset(32'd0);
            wait_error(c);
            n_total++;
            if (c !== 1 || dmem[0] !== FILL)
                $display("[TB] FAIL illegal_%0d: got cycle %0d dmem %h expected 1/%h", i, c, dmem[0], FILL);
            else n_pass++;
        end
    endtask

    task automatic gen_alu(input bit apply);
        int op, rd, rs1, rs2, imm;
        logic [31:0] b;
        bit use_imm;
        rd      = $urandom_range(0, 7);
        rs1     = $urandom_range(0, 7);
        rs2     = $urandom_range(0, 7);
        use_imm = 1'($urandom_range(0, 1));
        op      = $urandom_range(0, 9);
        if (use_imm && op == 1) op = 0;
        if (use_imm) begin
            if (op == 2 || op == 8 || op == 9) begin
                imm = $urandom_range(0, 31);
                b   = 32'(imm);
                if (op == 9) imm = imm | 'h400;
            end else begin
                imm = $urandom_range(0, 4095);
                b   = {{20{imm[11]}}, imm[11:0]};
            end
            emit(enc_i(imm, rs1, r_f3[op], rd, 'h13));
        end else begin
            b = mreg[rs2];
            emit(enc_r(r_f7[op], rs2, rs1, r_f3[op], rd));
        end
        if (apply && rd != 0) mreg[rd] = model_alu(op, mreg[rs1], b);
    endtask

    task automatic test_random_alu();
        int c, executed, k, hi, lo, f3, rs1, rs2;
        bit taken;
        for (int p = 0; p < 8; p++) begin
            clear_imem();
            executed = 0;
            for (int r = 0; r < 32; r++) mreg[r] = 32'd0;
            for (int r = 1; r <= 7; r++) begin
                hi = $urandom;
                lo = $urandom_range(0, 4095);
                emit(lui(r, hi));
                emit(addi(r, r, lo));
                mreg[r] = {hi[19:0], 12'd0} + {{20{lo[11]}}, lo[11:0]};
                executed += 2;
            end
            k = 0;
            while (k < 24) begin
                if ($urandom_range(0, 4) == 0) begin
                    f3    = b_f3[$urandom_range(0, 5)];
                    rs1   = $urandom_range(0, 7);
                    rs2   = $urandom_range(0, 7);
                    taken = model_branch(f3, mreg[rs1], mreg[rs2]);
                    emit(enc_b(f3, rs1, rs2, 8));
                    gen_alu(!taken);
                    executed += taken ? 1 : 2;
                    k += 2;
                end else begin
                    gen_alu(1'b1);
                    executed++;
                    k++;
                end
            end
            for (int r = 1; r <= 7; r++) emit(sw(r, 0, 4 * (r - 1)));
            executed += 7;
            emit(32'd0);
            do_reset(32'd0);
            wait_error(c);
            n_total++;
            if (c !== executed + 1) $display("[TB] FAIL rand%0d_cycles: got %0d expected %0d", p, c, executed + 1);
            else n_pass++;
            n_total++;
            if (ibus_add !== 32'(gen_pc - 4)) $display("[TB] FAIL rand%0d_pc: got %h expected %h", p, ibus_add, 32'(gen_pc - 4));
            else n_pass++;
            for (int r = 1; r <= 7; r++) begin
                n_total++;
                if (dmem[r - 1] !== mreg[r])
                    $display("[TB] FAIL rand%0d_x%0d: got %h expected %h", p, r, dmem[r - 1], mreg[r]);
                else n_pass++;
            end
            n_total++;
            if (dmem[7] !== FILL) $display("[TB] FAIL rand%0d_spill: got %h expected %h", p, dmem[7], FILL);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_alu();
        test_load_store();
        test_branches();
        test_jumps();
        test_shifts();
        test_error();
        test_illegal();
        test_random_alu();
        $display("[TB] %0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
